i2s_sample_fifo: RTL

//  First-word-fall-through sample FIFO sitting directly upstream of the I2S transmitter.

---
 rtl/audio_pkg.sv | 8 +
 rtl/sample_ram.sv | 30 +++
 rtl/i2s_sample_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants: sample width, silence code, default FIFO depth.
package audio_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;
    localparam int unsigned FIFO_ADDR_W = 4;

endpackage

// File: rtl/sample_ram.sv
// Sample storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write on rising edge), raddr/rdata (combinational read).
// Contents are not reset.
module sample_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives first-word-fall-through on the head entry
    assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// First-word-fall-through sample FIFO feeding the I2S transmitter.
// Ports: clk, rst_n (async, active low), flush / clr_status (sync clears),
//        wr_en/wr_data, full, almost_full (source side),
//        rd_en, fifo_out, fifo_empty, almost_empty (transmitter side),
//        level, overflow, underflow (sticky status).
// All flags are decoded from the pointer registers only.
module i2s_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = SAMPLE_W,
    parameter int unsigned ADDR_W    = FIFO_ADDR_W,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] fifo_out,
    output logic              fifo_empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_status
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [DATA_W-1:0] ram_rdata;
    logic              is_empty;
    logic              is_full;
    logic              do_push;
    logic              do_pop;
    logic              ovf_evt;
    logic              unf_evt;

    // Wrap-bit pointer compare
    assign is_empty = (wptr == rptr);
    assign is_full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

    // A pop on a full FIFO frees the slot the same edge, so the push still goes in
    assign do_pop  = rd_en & ~is_empty & ~flush;
    assign do_push = wr_en & (~is_full | rd_en) & ~flush;
    assign ovf_evt = wr_en & is_full & ~rd_en & ~flush;
    assign unf_evt = rd_en & is_empty & ~flush;

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Pointer registers; flush overrides any push/pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + PTR_W'(do_push);
            rptr <= rptr + PTR_W'(do_pop);
        end
    end

    // Sticky status; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt | (overflow & ~clr_status);
            underflow <= unf_evt | (underflow & ~clr_status);
        end
    end

    // Status decode; pointer difference is naturally modulo 2*DEPTH
    assign level        = wptr - rptr;
    assign fifo_empty   = is_empty;
    assign full         = is_full;
    assign almost_full  = (level >= AFULL_LVL);
    assign almost_empty = (level <= AEMPTY_LVL);
    assign fifo_out     = is_empty ? DATA_W'(SILENCE) : ram_rdata;

endmodule
